// File: rtl/pes_duty_btn_ctrl_if.sv
// Bundle of button inputs and duty-control outputs for the PWM front-end conditioner.
// The master side drives the buttons; the slave side is the conditioner.
interface pes_duty_btn_ctrl_if;
    logic btn_inc;
    logic btn_dec;
    logic repeat_en;
    logic increase_duty;
    logic decrease_duty;
    logic inc_level;
    logic dec_level;
    logic lockout;

    modport master (
        output btn_inc, btn_dec, repeat_en,
        input  increase_duty, decrease_duty, inc_level, dec_level, lockout
    );

    modport slave (
        input  btn_inc, btn_dec, repeat_en,
        output increase_duty, decrease_duty, inc_level, dec_level, lockout
    );
endinterface

// File: rtl/pes_duty_btn_ctrl.sv
// Synchronises and debounces two duty buttons, then turns presses into one-cycle
// increase/decrease pulses with optional auto-repeat and a both-pressed lockout.
module pes_duty_btn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 8,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst,
    pes_duty_btn_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HOLD_INC, HOLD_DEC, LOCKOUT} state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_DLY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_RATE = CNT_W'(REPEAT_RATE);

    // Channel 0 is the increase button, channel 1 the decrease button.
    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_level_next;

    assign w_raw = {bus.btn_dec, bus.btn_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic             r_sync1;
            logic             r_sync2;
            logic             r_level;
            logic [CNT_W-1:0] r_db_cnt;
            logic             w_lvl_nx;
            logic [CNT_W-1:0] w_cnt_nx;

            always_comb begin
                w_lvl_nx = r_level;
                w_cnt_nx = '0;
                if (r_sync2 != r_level) begin
                    if (r_db_cnt == DB_LAST) begin
                        w_lvl_nx = r_sync2;
                    end else begin
                        w_cnt_nx = r_db_cnt + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1  <= 1'b0;
                    r_sync2  <= 1'b0;
                    r_level  <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_sync1  <= w_raw[gi];
                    r_sync2  <= r_sync1;
                    r_level  <= w_lvl_nx;
                    r_db_cnt <= w_cnt_nx;
                end
            end

            assign w_level[gi]      = r_level;
            assign w_level_next[gi] = w_lvl_nx;
        end
    endgenerate

    // The FSM looks at the level being registered this edge so the press pulse
    // lands on the same edge the debounced level flips.
    logic w_inc_rise;
    logic w_dec_rise;
    assign w_inc_rise = w_level_next[0] & ~w_level[0];
    assign w_dec_rise = w_level_next[1] & ~w_level[1];

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_next;
    logic [CNT_W-1:0] w_timer_inc;
    logic [CNT_W-1:0] w_thresh;
    logic             r_first;
    logic             w_first_next;
    logic             w_inc_pulse;
    logic             w_dec_pulse;
    logic             r_inc_duty;
    logic             r_dec_duty;
    logic             r_lockout;

    assign w_timer_inc = r_timer + 1'b1;
    assign w_thresh    = r_first ? RPT_DLY : RPT_RATE;

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_first_next = r_first;
        w_inc_pulse  = 1'b0;
        w_dec_pulse  = 1'b0;
        case (r_state)
            IDLE: begin
                if ((w_inc_rise && w_level_next[1]) || (w_dec_rise && w_level_next[0])) begin
                    w_state_next = LOCKOUT;
                end else if (w_inc_rise) begin
                    w_state_next = HOLD_INC;
                    w_inc_pulse  = 1'b1;
                    w_timer_next = '0;
                    w_first_next = 1'b1;
                end else if (w_dec_rise) begin
                    w_state_next = HOLD_DEC;
                    w_dec_pulse  = 1'b1;
                    w_timer_next = '0;
                    w_first_next = 1'b1;
                end
            end
            HOLD_INC: begin
                if (!w_level_next[0]) begin
                    w_state_next = IDLE;
                end else if (w_dec_rise) begin
                    w_state_next = LOCKOUT;
                end else if (!bus.repeat_en) begin
                    w_timer_next = '0;
                end else if (w_timer_inc == w_thresh) begin
                    w_inc_pulse  = 1'b1;
                    w_timer_next = '0;
                    w_first_next = 1'b0;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            HOLD_DEC: begin
                if (!w_level_next[1]) begin
                    w_state_next = IDLE;
                end else if (w_inc_rise) begin
                    w_state_next = LOCKOUT;
                end else if (!bus.repeat_en) begin
                    w_timer_next = '0;
                end else if (w_timer_inc == w_thresh) begin
                    w_dec_pulse  = 1'b1;
                    w_timer_next = '0;
                    w_first_next = 1'b0;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            LOCKOUT: begin
                if (w_level_next == 2'b00) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_first    <= 1'b1;
            r_inc_duty <= 1'b0;
            r_dec_duty <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_first    <= w_first_next;
            r_inc_duty <= w_inc_pulse;
            r_dec_duty <= w_dec_pulse;
            r_lockout  <= (w_state_next == LOCKOUT);
        end
    end

    assign bus.increase_duty = r_inc_duty;
    assign bus.decrease_duty = r_dec_duty;
    assign bus.inc_level     = w_level[0];
    assign bus.dec_level     = w_level[1];
    assign bus.lockout       = r_lockout;
endmodule

// File: tb/tb_pes_duty_btn_ctrl.sv
// Scoreboard bench for pes_duty_btn_ctrl: a cycle-level reference model queues expected
// pulses, a negedge monitor pops and compares; directed scenarios plus random presses.
module tb_pes_duty_btn_ctrl;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 8;

    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_LOCK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pes_duty_btn_ctrl_if bus();

    pes_duty_btn_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .CNT_W          (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int kind; int cyc; } ev_t;   // kind 0 = increase, 1 = decrease
    ev_t expq[$];

    int cyc = 0;
    bit m_d1[2];
    bit m_s[2];
    int m_run[2];
    bit m_lvl[2];
    bit m_old[2];
    bit m_rise[2];
    int m_mode = M_IDLE;
    int m_held = 0;
    int m_age  = 0;
    bit m_first = 1'b1;
    bit m_raw[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_d1[c] = 0; m_s[c] = 0; m_run[c] = 0; m_lvl[c] = 0;
            end
            m_mode = M_IDLE; m_age = 0; m_first = 1'b1;
            expq.delete();
        end else begin
            cyc++;
            m_raw[0] = bus.btn_inc;
            m_raw[1] = bus.btn_dec;
            // Debounce: the level follows the synchronised input after DEB straight disagreements.
            for (int c = 0; c < 2; c++) begin
                m_old[c] = m_lvl[c];
                if (m_s[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_lvl[c] = m_s[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s[c]    = m_d1[c];
                m_d1[c]   = m_raw[c];
                m_rise[c] = m_lvl[c] && !m_old[c];
            end
            if (m_mode == M_IDLE) begin
                if ((m_rise[0] && m_lvl[1]) || (m_rise[1] && m_lvl[0])) begin
                    m_mode = M_LOCK;
                end else if (m_rise[0] || m_rise[1]) begin
                    m_held = m_rise[0] ? 0 : 1;
                    m_mode = M_HOLD; m_age = 0; m_first = 1'b1;
                    expq.push_back('{m_held, cyc});
                end
            end else if (m_mode == M_HOLD) begin
                if (!m_lvl[m_held]) begin
                    m_mode = M_IDLE;
                end else if (m_rise[1 - m_held]) begin
                    m_mode = M_LOCK;
                end else if (!bus.repeat_en) begin
                    m_age = 0;
                end else begin
                    m_age++;
                    if (m_age == (m_first ? RD : RR)) begin
                        expq.push_back('{m_held, cyc});
                        m_age = 0; m_first = 1'b0;
                    end
                end
            end else if (!m_lvl[0] && !m_lvl[1]) begin
                m_mode = M_IDLE;
            end
        end
    end

    // ---------------- monitor ----------------
    int n_inc = 0;
    int n_dec = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {bus.increase_duty, bus.decrease_duty, bus.inc_level,
                                  bus.dec_level, bus.lockout}, 0);
        end else begin
            int exp_vec;
            exp_vec = 0;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                ev_t e;
                e = expq.pop_front();
                exp_vec = (e.kind == 0) ? 1 : 2;
            end
            if (expq.size() > 0 && expq[0].cyc < cyc) begin
                chk("stale_expected_pulse", expq[0].cyc, cyc);
                expq.delete();
            end
            chk("pulse_dec_inc", {bus.decrease_duty, bus.increase_duty}, exp_vec);
            chk("levels_dec_inc", {bus.dec_level, bus.inc_level}, {m_lvl[1], m_lvl[0]});
            chk("lockout", bus.lockout, (m_mode == M_LOCK) ? 1 : 0);
            if (bus.increase_duty) n_inc++;
            if (bus.decrease_duty) n_dec++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit inc, input bit dec);
        @(negedge clk);
        bus.btn_inc = inc;
        bus.btn_dec = dec;
    endtask

    task automatic do_reset(input int len);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("reset_immediate", {bus.increase_duty, bus.decrease_duty, bus.inc_level,
                                   bus.dec_level, bus.lockout}, 0);
        repeat (len) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    int base_i;
    int base_d;

    initial begin
        bus.btn_inc   = 1'b0;
        bus.btn_dec   = 1'b0;
        bus.repeat_en = 1'b0;
        cycles(3);
        #2 rst = 1'b0;
        cycles(3);

        // Single press, no repeat: level and pulse exactly 2+DEB edges after raw rise.
        base_i = n_inc; base_d = n_dec;
        drive(1, 0);
        repeat (5) @(posedge clk);
        #1 chk("sc1_level_before", bus.inc_level, 0);
        @(posedge clk);
        #1 chk("sc1_level_at6", bus.inc_level, 1);
        chk("sc1_pulse_at6", bus.increase_duty, 1);
        @(posedge clk);
        #1 chk("sc1_pulse_width", bus.increase_duty, 0);
        cycles(100);
        drive(0, 0);
        cycles(20);
        chk("sc1_inc_count", n_inc - base_i, 1);
        chk("sc1_dec_count", n_dec - base_d, 0);

        // Bounce shorter than the debounce window never reaches the level.
        base_d = n_dec;
        drive(0, 1); cycles(2);
        drive(0, 0); cycles(1);
        drive(0, 1); cycles(2);
        drive(0, 0); cycles(20);
        chk("sc2_dec_count", n_dec - base_d, 0);
        chk("sc2_dec_level", bus.dec_level, 0);

        // Auto-repeat: initial pulse then +RD, then every RR while held.
        bus.repeat_en = 1'b1;
        base_i = n_inc;
        drive(1, 0);
        repeat (6) @(posedge clk);
        #1 chk("sc3_initial_pulse", bus.increase_duty, 1);
        repeat (48) @(posedge clk);
        @(negedge clk);
        bus.btn_inc = 1'b0;
        cycles(40);
        chk("sc3_repeat_count", n_inc - base_i, 6);
        bus.repeat_en = 1'b0;

        // Lockout entered by a second press, held until both are released.
        base_i = n_inc; base_d = n_dec;
        drive(1, 0); cycles(12);
        drive(1, 1); cycles(10);
        chk("sc4_locked", bus.lockout, 1);
        drive(1, 0); cycles(15);
        chk("sc4_still_locked", bus.lockout, 1);
        drive(0, 0); cycles(15);
        chk("sc4_unlocked", bus.lockout, 0);
        chk("sc4_inc_count", n_inc - base_i, 1);
        drive(0, 1); cycles(15);
        drive(0, 0); cycles(15);
        chk("sc4_dec_count", n_dec - base_d, 1);

        // Both buttons in the same cycle.
        base_i = n_inc; base_d = n_dec;
        drive(1, 1); cycles(12);
        chk("sc5_locked", bus.lockout, 1);
        drive(0, 0); cycles(15);
        chk("sc5_pulses", (n_inc - base_i) + (n_dec - base_d), 0);

        // Reset mid-hold: held button re-debounces and pulses again.
        base_i = n_inc;
        drive(1, 0); cycles(12);
        do_reset(2);
        repeat (5) @(posedge clk);
        #1 chk("sc6_no_early_pulse", bus.increase_duty, 0);
        @(posedge clk);
        #1 chk("sc6_fresh_pulse", bus.increase_duty, 1);
        drive(0, 0); cycles(15);
        chk("sc6_inc_count", n_inc - base_i, 2);

        // Random presses, bounces, repeat toggling and occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset($urandom_range(1, 3));
            end else begin
                bit bi, bd;
                bi = ($urandom_range(0, 99) < 45);
                bd = ($urandom_range(0, 99) < 30);
                drive(bi, bd);
                bus.repeat_en = ($urandom_range(0, 1) == 1);
                cycles((r < 40) ? $urandom_range(1, 6) : $urandom_range(5, 60));
            end
        end
        drive(0, 0);
        cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pes_duty_btn_ctrl.md
Name: pes_duty_btn_ctrl

Overview:
Front-end conditioner for the PWM generator's duty controls.
- Takes two raw, asynchronous, bouncing push-button inputs.
- Synchronises and debounces each one.
- Produces clean single-cycle increase_duty / decrease_duty pulses that drive the PWM generator directly.
- Optional auto-repeat while a button is held; lockout when both buttons are pressed.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised input must differ from the debounced level before the level flips (>=1).
REPEAT_DELAY, 20, cycles from the initial press pulse to the first auto-repeat pulse (>=1).
REPEAT_RATE, 8, cycles between subsequent auto-repeat pulses (>=1).
CNT_W, 16, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
btn_inc  input  1  raw increase button, asynchronous
btn_dec  input  1  raw decrease button, asynchronous
repeat_en  input  1  synchronous; 1 = auto-repeat enabled while held
increase_duty  output  1  one-cycle pulse to PWM generator
decrease_duty  output  1  one-cycle pulse to PWM generator
inc_level  output  1  debounced level of btn_inc
dec_level  output  1  debounced level of btn_dec
lockout  output  1  high while the FSM is in LOCKOUT

Behaviour:
Clock and reset
- One clock: clk. Reset rst is asynchronous and active-high.
- While rst is high, all flops are cleared immediately: sync stages, debounce counters, levels, repeat timer, FSM=IDLE, all outputs 0.
- Reset mid-press: after rst deasserts, a held button must fully re-debounce. It then produces a fresh initial pulse.

Synchronise
- Two-flop synchroniser per button, giving s_inc and s_dec.

Debounce (per channel)
- Counter increments on each edge where s_x != x_level.
- Counter clears on any edge where s_x == x_level.
- On the DEBOUNCE_CYCLES-th consecutive differing edge: x_level <= s_x and the counter clears.
- Raw-to-level latency: 2 + DEBOUNCE_CYCLES edges.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles has no effect.

FSM states: IDLE, HOLD_INC, HOLD_DEC, LOCKOUT.
- IDLE:
  - inc_level rises and dec_level stays 0 -> pulse increase_duty, go to HOLD_INC, timer=0.
  - dec_level rises and inc_level stays 0 -> pulse decrease_duty, go to HOLD_DEC, timer=0.
  - Both levels high in the same cycle -> no pulse, go to LOCKOUT.
- HOLD_x:
  - x_level falls -> IDLE, no pulse.
  - Opposite level rises -> LOCKOUT, no pulse.
  - Otherwise, if repeat_en=1, the timer increments each cycle.
  - Timer reaches REPEAT_DELAY (first repeat) or REPEAT_RATE (later repeats) -> one-cycle pulse, timer=0.
  - repeat_en=0 holds the timer at 0. When repeat_en is raised, counting starts from 0 and the first-repeat flag is kept.
- LOCKOUT:
  - No pulses.
  - Exit to IDLE only when both levels are 0.
  - A new press needs a new rising edge of a level.

Outputs
- Pulse outputs are registered and high for exactly one cycle: the cycle in which the FSM transition/repeat event is registered.
- increase_duty and decrease_duty are never high together.
- lockout = (state==LOCKOUT), registered.

Test Plan:
- Defaults; btn_inc 0->1 held 100 cycles, repeat_en=0 -> inc_level high after 6 edges; exactly one increase_duty pulse, 1 cycle wide, 6 edges after raw rise; decrease_duty stays 0.
- btn_dec bounces: high 3 cycles, low 2, high 3, low -> dec_level never rises; zero pulses; debounce counter returns to 0.
- repeat_en=1, btn_inc held 60 cycles after initial pulse at cycle T -> pulses at T, T+20, T+28, T+36, T+44, T+52; none after release.
- btn_inc held, then btn_dec pressed -> lockout=1 after dec debounce, no further pulses; release dec only -> still locked; release both -> lockout=0, next btn_dec press gives one decrease_duty.
- Both buttons rising in the same cycle -> lockout=1, zero pulses on either output.
- rst pulsed mid-hold in HOLD_INC with btn_inc still held -> outputs 0 immediately; after deassert, one new increase_duty 6 edges later.
